pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and forwarding controller for the five-stage ARM pipeline: issues stall, flush and forward-select controls to the fetch/decode, decode/execute and execute/memory pipeline registers. It keeps its own shadow of the destination-register information held in the E, M and W stages, and uses it to resolve load-use hazards, taken branches and multi-cycle data-memory waits. It also keeps stall/flush performance counters and a sticky memory-timeout flag for the camera-attached data memory.

## Interface
- REG_BITS, 4: register-address width.
- PERF_WIDTH, 16: width of each performance counter.
- MAX_WAIT, 15: maximum consecutive mem_busy_m cycles before timeout.

- clk  in  1  single pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid_d  in  1  decode stage holds a real instruction.
- ra1_d, ra2_d  in  REG_BITS  decode source registers.
- use_ra1_d, use_ra2_d  in  1  source operand actually read.
- wa3_d  in  REG_BITS  decode destination register.
- regwrite_d, memtoreg_d  in  1  decode writes a register / the write is a load.
- branch_taken_e  in  1  branch in E is taken (PC redirect this cycle).
- mem_busy_m  in  1  data memory needs another cycle for the M-stage access.
- stall_f, stall_d  out  1  hold the PC and the fetch/decode register.
- flush_d, flush_e  out  1  clear the fetch/decode register and the decode/execute register.
- stall_e, stall_m  out  1  hold the decode/execute and execute/memory registers.
- fwd_a_e, fwd_b_e  out  2  E operand select: 00 register file, 01 W result, 10 M ALU result.
- stall_count, flush_count  out  PERF_WIDTH  cycles with stall_d=1 / cycles with flush_e=1.
- mem_timeout  out  1  sticky error flag.

## Operation
- Shadow records E, M, W each hold {valid, wa3, regwrite, memtoreg}. E also holds {ra1, ra2, use_ra1, use_ra2}.
- Advance on each clk edge when not frozen:
  - D→E captures the decode inputs, or a bubble (valid=0) if flush_e=1.
  - E→M and M→W shift normally.
- Freeze (mem_busy_m=1):
  - stall_f, stall_d, stall_e and stall_m are all 1; flush_d and flush_e are 0.
  - E and M hold. W receives a bubble.
- Priority, evaluated combinationally each cycle:
  1. memory freeze.
  2. Branch: branch_taken_e=1 → flush_d=1, flush_e=1, no stalls.
  3. Load-use: E.valid & E.regwrite & E.memtoreg & E.wa3 matches a used decode source (issue_valid_d) → stall_f=1, stall_d=1, flush_e=1.
  4. Otherwise all controls are 0.
- A branch held during a freeze takes effect in the first cycle after mem_busy_m falls.
- Forwarding for each E source (ra1 shown; ra2 is identical):
  - 10 if M.valid & M.regwrite & ~M.memtoreg & M.wa3==ra1_e.
  - else 01 if W.valid & W.regwrite & W.wa3==ra1_e.
  - else 00.
  - Forwarding is 00 when use_ra1_e=0, when E.valid=0, or when the register is R15 (address all-ones); R15 is never forwarded and never causes a load-use stall.
- Wait FSM states:
  - RUN → WAIT when mem_busy_m=1.
  - WAIT → RUN when mem_busy_m=0.
  - The wait counter clears on entering RUN and increments each cycle in WAIT, saturating at MAX_WAIT.
  - mem_timeout is set when mem_busy_m=1 with the counter already at MAX_WAIT. It is cleared only by rst.
- Performance counters increment by 1 per qualifying cycle and saturate at all-ones (no wrap).

## Timing
- Reset (asynchronous, immediate): all shadow records invalid, FSM=RUN, wait counter=0, counters=0, mem_timeout=0.
  - With idle inputs, all stall/flush/fwd outputs read 0 in the cycle after reset.
- stall_*, flush_* and fwd_* are combinational from the registered records and the current inputs, valid in the same cycle.
  - The pipeline registers use them at the next rising edge.
- A load-use stall lasts exactly 1 cycle. The bubble then moves the load to M, and the hazard clears.
- A branch flush lasts 1 cycle per cycle of branch_taken_e.
- Load-use and branch in the same cycle: branch wins; no stall, stall_count unchanged, flush_count +1.
- mem_busy_m together with branch or load-use: freeze wins, and stall_count increments.
- Reset asserted mid-freeze or mid-stall: outputs return to reset values asynchronously, with no residual stall after release.

## Test plan
- Dependent ALU ops: r1=ADD then SUB using r1 in the next instruction → fwd_a_e=10 for 1 cycle; with one instruction between them, fwd_a_e=01.
- Load-use: LDR r2 followed immediately by ADD using r2 → stall_f=stall_d=flush_e=1 for exactly 1 cycle, then fwd=01, stall_count=1.
- Taken branch with a load-use hazard in the same cycle → flush_d=flush_e=1, stall_d=0, flush_count=1, stall_count=0.
- mem_busy_m high for 3 cycles → all four stalls high for 3 cycles, E/M forwarding unchanged, W bubble, mem_timeout=0.
- mem_busy_m high for MAX_WAIT+1 cycles → mem_timeout=1 and remains set after busy drops; after rst, mem_timeout=0 and the counters read 0.
- Writes to R15 followed by a reader of R15, plus 2^PERF_WIDTH+5 stall cycles → fwd stays 00 and stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute/memory-side handshake between the pipeline datapath and the hazard controller.
// The datapath side is the master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int REG_BITS   = 4,
    parameter int PERF_WIDTH = 16
);
    logic                  issue_valid_d;
    logic [REG_BITS-1:0]   ra1_d;
    logic [REG_BITS-1:0]   ra2_d;
    logic                  use_ra1_d;
    logic                  use_ra2_d;
    logic [REG_BITS-1:0]   wa3_d;
    logic                  regwrite_d;
    logic                  memtoreg_d;
    logic                  branch_taken_e;
    logic                  mem_busy_m;

    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic                  stall_e;
    logic                  stall_m;
    logic [1:0]            fwd_a_e;
    logic [1:0]            fwd_b_e;
    logic [PERF_WIDTH-1:0] stall_count;
    logic [PERF_WIDTH-1:0] flush_count;
    logic                  mem_timeout;

    modport master (
        output issue_valid_d, ra1_d, ra2_d, use_ra1_d, use_ra2_d, wa3_d,
               regwrite_d, memtoreg_d, branch_taken_e, mem_busy_m,
        input  stall_f, stall_d, flush_d, flush_e, stall_e, stall_m,
               fwd_a_e, fwd_b_e, stall_count, flush_count, mem_timeout
    );

    modport slave (
        input  issue_valid_d, ra1_d, ra2_d, use_ra1_d, use_ra2_d, wa3_d,
               regwrite_d, memtoreg_d, branch_taken_e, mem_busy_m,
        output stall_f, stall_d, flush_d, flush_e, stall_e, stall_m,
               fwd_a_e, fwd_b_e, stall_count, flush_count, mem_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage pipeline, with its own E/M/W destination shadow.
// Wait FSM:  ST_RUN  | data memory responding, wait counter held at 0
//            ST_WAIT | M-stage access stretched by mem_busy_m, counter tracks busy cycles
module pipe_hazard_ctrl #(
    parameter int REG_BITS   = 4,
    parameter int PERF_WIDTH = 16,
    parameter int MAX_WAIT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int                 CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]      CNT_MAX = CW'(MAX_WAIT);
    localparam logic [REG_BITS-1:0] PC_REG = '1;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] wa3;
        logic                regwrite;
        logic                memtoreg;
    } rec_t;

    typedef enum logic {ST_RUN, ST_WAIT} wstate_t;

    rec_t                  e_q, m_q, w_q;
    logic [REG_BITS-1:0]   e_ra1, e_ra2;
    logic                  e_use1, e_use2;
    wstate_t               state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PERF_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic                  timeout_q;
    logic                  freeze, hit1, hit2, load_use;
    logic                  stall_f, stall_d, flush_d, flush_e, stall_e, stall_m;

    // M only forwards ALU results; a load in M is still in flight.
    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] ra, input logic use_ra,
                                           input logic e_valid, input rec_t m, input rec_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_valid && use_ra && ra != PC_REG) begin
            if (m.valid && m.regwrite && !m.memtoreg && m.wa3 == ra)
                sel = 2'b10;
            else if (w.valid && w.regwrite && w.wa3 == ra)
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign freeze   = hz.mem_busy_m;
    assign hit1     = hz.use_ra1_d && (hz.ra1_d == e_q.wa3);
    assign hit2     = hz.use_ra2_d && (hz.ra2_d == e_q.wa3);
    assign load_use = hz.issue_valid_d && e_q.valid && e_q.regwrite && e_q.memtoreg &&
                      (e_q.wa3 != PC_REG) && (hit1 || hit2);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (hz.branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            e_ra1  <= '0;
            e_ra2  <= '0;
            e_use1 <= 1'b0;
            e_use2 <= 1'b0;
        end else if (freeze) begin
            w_q <= '0;
        end else begin
            if (flush_e)
                e_q <= '0;
            else
                e_q <= '{valid: hz.issue_valid_d, wa3: hz.wa3_d,
                         regwrite: hz.regwrite_d, memtoreg: hz.memtoreg_d};
            e_ra1  <= hz.ra1_d;
            e_ra2  <= hz.ra2_d;
            e_use1 <= hz.use_ra1_d;
            e_use2 <= hz.use_ra2_d;
            m_q    <= e_q;
            w_q    <= m_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN:  if (hz.mem_busy_m)  state_d = ST_WAIT;
            ST_WAIT: if (!hz.mem_busy_m) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (state_d == ST_RUN)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hz.mem_busy_m && cnt_q == CNT_MAX)
                timeout_q <= 1'b1;
            if (stall_d && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_e && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign hz.stall_f     = stall_f;
    assign hz.stall_d     = stall_d;
    assign hz.flush_d     = flush_d;
    assign hz.flush_e     = flush_e;
    assign hz.stall_e     = stall_e;
    assign hz.stall_m     = stall_m;
    assign hz.fwd_a_e     = fwd_sel(e_ra1, e_use1, e_q.valid, m_q, w_q);
    assign hz.fwd_b_e     = fwd_sel(e_ra2, e_use2, e_q.valid, m_q, w_q);
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
    assign hz.mem_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: each scenario queues expected control vectors as it drives
// decode/branch/busy inputs and pops them when the combinational controls settle.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [9:0] exp_q[$];

    pipe_hazard_ctrl_if #(.REG_BITS(4), .PERF_WIDTH(16)) hz ();

    pipe_hazard_ctrl #(.REG_BITS(4), .PERF_WIDTH(16), .MAX_WAIT(15)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    always #5 clk = ~clk;

    // {stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, fwd_a_e, fwd_b_e}
    wire [9:0] ctl = {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e, hz.stall_e, hz.stall_m,
                      hz.fwd_a_e, hz.fwd_b_e};

    localparam logic [9:0] C_0   = 10'b0000000000;
    localparam logic [9:0] C_LU  = 10'b1101000000;
    localparam logic [9:0] C_BR  = 10'b0011000000;
    localparam logic [9:0] C_FRZ = 10'b1100110000;
    localparam logic [9:0] A10   = 10'b0000001000;
    localparam logic [9:0] A01   = 10'b0000000100;
    localparam logic [9:0] B10   = 10'b0000000010;
    localparam logic [9:0] B01   = 10'b0000000001;
    localparam logic [16:0] NOP  = 17'd0;

    function automatic logic [16:0] ins(input logic v, input logic [3:0] a1, input logic u1,
                                        input logic [3:0] a2, input logic u2, input logic [3:0] wd,
                                        input logic rw, input logic mt);
        return {v, a1, u1, a2, u2, wd, rw, mt};
    endfunction

    // stimulus word: {branch_taken_e, mem_busy_m, decode instruction}
    task automatic apply(input logic [18:0] s);
        hz.branch_taken_e = s[18];
        hz.mem_busy_m     = s[17];
        {hz.issue_valid_d, hz.ra1_d, hz.use_ra1_d, hz.ra2_d, hz.use_ra2_d,
         hz.wa3_d, hz.regwrite_d, hz.memtoreg_d} = s[16:0];
    endtask

    task automatic do_reset();
        apply({2'b00, NOP});
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        rst = 1'b1;
        apply({2'b00, NOP});
        #1;
        total++;
        if (hz.stall_count !== 16'd0 || hz.flush_count !== 16'd0 || hz.mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs: got stall=%0d flush=%0d tmo=%b want 0 0 0",
                     hz.stall_count, hz.flush_count, hz.mem_timeout);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(C_0);
            #1 e = exp_q.pop_front();
            total++;
            if (ctl !== e) begin
                bad++;
                $display("FAIL reset_ctl step %0d: got %b want %b", i, ctl, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fwd_alu();
        logic [16:0] i0 = ins(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0);
        logic [16:0] i1 = ins(1, 4'd1, 1, 4'd5, 1, 4'd4, 1, 0);
        logic [16:0] i2 = ins(1, 4'd6, 1, 4'd1, 1, 4'd8, 1, 0);
        logic [18:0] s[5];
        logic [9:0]  ex[5];
        logic [9:0]  e;
        s  = '{{2'b00, i0}, {2'b00, i1}, {2'b00, i2}, {2'b00, NOP}, {2'b00, NOP}};
        ex = '{C_0, C_0, A10, B01, C_0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            exp_q.push_back(ex[i]);
            #1 e = exp_q.pop_front();
            total++;
            if (ctl !== e) begin
                bad++;
                $display("FAIL fwd_alu step %0d: got %b want %b", i, ctl, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        logic [16:0] ld = ins(1, 4'd3, 1, 4'd0, 0, 4'd2, 1, 1);
        logic [16:0] ad = ins(1, 4'd2, 1, 4'd6, 1, 4'd5, 1, 0);
        logic [16:0] un = ins(1, 4'd7, 1, 4'd2, 0, 4'd9, 1, 0);
        logic [18:0] s[7];
        logic [9:0]  ex[7];
        logic [9:0]  e;
        s  = '{{2'b00, ld}, {2'b00, ad}, {2'b00, ad}, {2'b00, NOP}, {2'b00, NOP},
               {2'b00, ld}, {2'b00, un}};
        ex = '{C_0, C_LU, C_0, A01, C_0, C_0, C_0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            exp_q.push_back(ex[i]);
            #1 e = exp_q.pop_front();
            total++;
            if (ctl !== e) begin
                bad++;
                $display("FAIL load_use step %0d: got %b want %b", i, ctl, e);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (hz.stall_count !== 16'd1 || hz.flush_count !== 16'd1) begin
            bad++;
            $display("FAIL load_use_counts: got stall=%0d flush=%0d want 1 1",
                     hz.stall_count, hz.flush_count);
        end
    endtask

    task automatic test_branch();
        logic [16:0] ld = ins(1, 4'd3, 1, 4'd0, 0, 4'd2, 1, 1);
        logic [16:0] ad = ins(1, 4'd2, 1, 4'd6, 1, 4'd5, 1, 0);
        logic [18:0] s[6];
        logic [9:0]  ex[6];
        logic [9:0]  e;
        s  = '{{2'b00, ld}, {2'b10, ad}, {2'b00, NOP}, {2'b11, NOP}, {2'b10, NOP}, {2'b00, NOP}};
        ex = '{C_0, C_BR, C_0, C_FRZ, C_BR, C_0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            exp_q.push_back(ex[i]);
            #1 e = exp_q.pop_front();
            total++;
            if (ctl !== e) begin
                bad++;
                $display("FAIL branch step %0d: got %b want %b", i, ctl, e);
            end
            @(posedge clk);
            #1;
            if (i == 2) begin
                total++;
                if (hz.stall_count !== 16'd0 || hz.flush_count !== 16'd1) begin
                    bad++;
                    $display("FAIL branch_lu_counts: got stall=%0d flush=%0d want 0 1",
                             hz.stall_count, hz.flush_count);
                end
            end
        end
        total++;
        if (hz.stall_count !== 16'd1 || hz.flush_count !== 16'd2) begin
            bad++;
            $display("FAIL branch_freeze_counts: got stall=%0d flush=%0d want 1 2",
                     hz.stall_count, hz.flush_count);
        end
    endtask

    task automatic test_mem_busy();
        logic [16:0] i0 = ins(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0);
        logic [16:0] i1 = ins(1, 4'd8, 1, 4'd9, 1, 4'd7, 1, 0);
        logic [16:0] i2 = ins(1, 4'd1, 1, 4'd7, 1, 4'd10, 1, 0);
        logic [18:0] s[8];
        logic [9:0]  ex[8];
        logic [9:0]  e;
        s  = '{{2'b00, i0}, {2'b00, i1}, {2'b00, i2}, {2'b01, NOP}, {2'b01, NOP}, {2'b01, NOP},
               {2'b00, NOP}, {2'b00, NOP}};
        ex = '{C_0, C_0, C_0, C_FRZ | A01 | B10, C_FRZ | B10, C_FRZ | B10, B10, C_0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(s[i]);
            exp_q.push_back(ex[i]);
            #1 e = exp_q.pop_front();
            total++;
            if (ctl !== e) begin
                bad++;
                $display("FAIL mem_busy step %0d: got %b want %b", i, ctl, e);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (hz.stall_count !== 16'd3 || hz.flush_count !== 16'd0 || hz.mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL mem_busy_counts: got stall=%0d flush=%0d tmo=%b want 3 0 0",
                     hz.stall_count, hz.flush_count, hz.mem_timeout);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply({2'b01, NOP});
            exp_q.push_back(C_FRZ);
            #1 e = exp_q.pop_front();
            total++;
            if (ctl !== e) begin
                bad++;
                $display("FAIL timeout_freeze step %0d: got %b want %b", i, ctl, e);
            end
            if (i == 15) begin
                total++;
                if (hz.mem_timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_early: got %b want 0", hz.mem_timeout);
                end
            end
            @(posedge clk);
            #1;
        end
        apply({2'b00, NOP});
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (hz.mem_timeout !== 1'b1) begin
                bad++;
                $display("FAIL timeout_sticky step %0d: got %b want 1", i, hz.mem_timeout);
            end
            @(posedge clk);
            #1;
        end
        apply({2'b01, NOP});
        @(posedge clk);
        #2 rst = 1'b1;
        apply({2'b00, NOP});
        #1;
        total++;
        if (hz.mem_timeout !== 1'b0 || hz.stall_count !== 16'd0 || hz.flush_count !== 16'd0 ||
            ctl !== C_0) begin
            bad++;
            $display("FAIL timeout_reset: got tmo=%b stall=%0d flush=%0d ctl=%b want 0 0 0 %b",
                     hz.mem_timeout, hz.stall_count, hz.flush_count, ctl, C_0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ctl !== C_0 || hz.stall_count !== 16'd0) begin
            bad++;
            $display("FAIL timeout_release: got ctl=%b stall=%0d want %b 0", ctl, hz.stall_count, C_0);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [16:0] ld = ins(1, 4'd3, 1, 4'd0, 0, 4'd2, 1, 1);
        logic [16:0] ad = ins(1, 4'd2, 1, 4'd6, 1, 4'd5, 1, 0);
        logic [9:0]  e;
        do_reset();
        apply({2'b00, ld});
        @(posedge clk);
        #1 apply({2'b00, ad});
        exp_q.push_back(C_LU);
        #1 e = exp_q.pop_front();
        total++;
        if (ctl !== e) begin
            bad++;
            $display("FAIL mid_stall_pre: got %b want %b", ctl, e);
        end
        rst = 1'b1;
        exp_q.push_back(C_0);
        #1 e = exp_q.pop_front();
        total++;
        if (ctl !== e || hz.stall_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_stall_reset: got ctl=%b stall=%0d want %b 0", ctl, hz.stall_count, e);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 apply({2'b00, NOP});
        exp_q.push_back(C_0);
        #1 e = exp_q.pop_front();
        total++;
        if (ctl !== e || hz.stall_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_stall_release: got ctl=%b stall=%0d want %b 0", ctl, hz.stall_count, e);
        end
    endtask

    task automatic test_r15_saturate();
        logic [16:0] w15 = ins(1, 4'd2, 1, 4'd3, 1, 4'd15, 1, 0);
        logic [16:0] r15 = ins(1, 4'd15, 1, 4'd15, 1, 4'd6, 1, 0);
        logic [16:0] oth = ins(1, 4'd2, 1, 4'd3, 1, 4'd9, 1, 0);
        logic [16:0] l15 = ins(1, 4'd2, 1, 4'd0, 0, 4'd15, 1, 1);
        logic [18:0] s[10];
        logic [9:0]  e;
        s = '{{2'b00, w15}, {2'b00, r15}, {2'b00, NOP}, {2'b00, w15}, {2'b00, oth},
              {2'b00, r15}, {2'b00, NOP}, {2'b00, l15}, {2'b00, r15}, {2'b00, NOP}};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(s[i]);
            exp_q.push_back(C_0);
            #1 e = exp_q.pop_front();
            total++;
            if (ctl !== e) begin
                bad++;
                $display("FAIL r15 step %0d: got %b want %b", i, ctl, e);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (hz.stall_count !== 16'd0) begin
            bad++;
            $display("FAIL r15_no_stall: got stall=%0d want 0", hz.stall_count);
        end
        apply({2'b01, NOP});
        repeat (65541) @(posedge clk);
        #1 apply({2'b00, NOP});
        #1;
        total++;
        if (hz.stall_count !== 16'hFFFF || hz.flush_count !== 16'd0) begin
            bad++;
            $display("FAIL stall_saturate: got stall=%h flush=%h want ffff 0000",
                     hz.stall_count, hz.flush_count);
        end
    endtask

    initial begin
        apply({2'b00, NOP});
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_timeout();
        test_reset_mid_stall();
        test_r15_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
